// File: rtl/pselect_pkg.sv
// Shared definitions for the round-robin priority selectors: search direction
// codes, an index carrier type and the modular search-position helper.
package pselect_pkg;
  localparam int DIR_ASC   = 0;
  localparam int DIR_DESC  = 1;
  localparam int IDX_W_MAX = 8;

  typedef logic [IDX_W_MAX-1:0] idx_t;

  // Position 'off' steps away from 'base' in direction 'dir', wrapped into [0, n).
  // Valid for base and off both in [0, n).
  function automatic int rr_pos(int base, int off, int n, int dir);
    int p;
    p = (dir == DIR_ASC) ? base + off : base - off;
    if (p >= n)     p = p - n;
    else if (p < 0) p = p + n;
    return p;
  endfunction
endpackage

// File: rtl/pselect_RS.sv
// Single-slot round-robin engine: one-hot grant to the first requester found
// starting at 'sel' and walking in direction DIR with wrap at N.
module pselect_RS
  import pselect_pkg::*;
#(
  parameter int N   = 8,
  parameter int DIR = DIR_ASC
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] sel,
  output logic [N-1:0]         gnt
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] pos;
  logic          found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    pos   = '0;
    for (int j = 0; j < N; j++) begin
      pos = IW'(rr_pos(int'(sel), j, N, DIR));
      if (!found && req[pos]) begin
        gnt[pos] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pselect_rr.sv
// Multi-grant round-robin selector: up to W of N requesters per cycle, with an
// auto-advancing pointer. Define PSELECT_RR_STARVE_EN for age-based forced grants.
module pselect_rr
  import pselect_pkg::*;
#(
  parameter int N          = 8,
  parameter int W          = 2,
  parameter int DIR        = DIR_ASC,
  parameter int STARVE_MAX = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N-1:0]           req,
  input  logic                   en,
  input  logic                   hold,
  output logic [W*N-1:0]         gnt,
  output logic [W-1:0]           gnt_valid,
  output logic [W*$clog2(N)-1:0] gnt_idx,
  output logic [N-1:0]           gnt_bus,
  output logic [$clog2(N)-1:0]   ptr
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q, ptr_d, last_idx;
  logic [N-1:0]  req_eff, slot0_req, starve_vec;

  assign req_eff = en ? req : '0;

`ifdef PSELECT_RR_STARVE_EN
  localparam int AW = $clog2(STARVE_MAX + 1);

  logic [N-1:0][AW-1:0] age_q, age_d;

  always_comb begin
    starve_vec = '0;
    for (int i = 0; i < N; i++)
      starve_vec[i] = req_eff[i] && (age_q[i] == AW'(STARVE_MAX));
  end

  always_comb begin
    age_d = age_q;
    for (int i = 0; i < N; i++) begin
      if (!req[i] || gnt_bus[i])                   age_d[i] = '0;
      else if (en && age_q[i] != AW'(STARVE_MAX))  age_d[i] = age_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) age_q <= '0;
    else        age_q <= age_d;
  end
`else
  logic unused_starve;
  assign starve_vec    = '0;
  assign unused_starve = ^STARVE_MAX;
`endif

  // The first starved requester in search order is exactly what a slot engine
  // returns when fed only the starved mask, so slot 0 simply swaps its input.
  assign slot0_req = (|starve_vec) ? starve_vec : req_eff;

  for (genvar k = 0; k < W; k++) begin : g_slot
    logic [N-1:0] s_req, s_gnt, taken;
    if (k == 0) begin : g_first
      assign s_req = slot0_req;
      assign taken = s_gnt;
    end else begin : g_rest
      assign s_req = req_eff & ~g_slot[k-1].taken;
      assign taken = g_slot[k-1].taken | s_gnt;
    end
    pselect_RS #(.N(N), .DIR(DIR)) u_rs (
      .req (s_req),
      .sel (ptr_q),
      .gnt (s_gnt)
    );
    assign gnt[k*N +: N] = s_gnt;
    assign gnt_valid[k]  = |s_gnt;
  end

  always_comb begin
    gnt_bus = '0;
    gnt_idx = '0;
    for (int k = 0; k < W; k++) begin
      gnt_bus = gnt_bus | gnt[k*N +: N];
      for (int i = 0; i < N; i++)
        if (gnt[k*N + i]) gnt_idx[k*IW +: IW] = IW'(i);
    end
  end

  // Valid slots fill from 0 upward, so the last valid one holds the final winner.
  always_comb begin
    last_idx = '0;
    for (int k = 0; k < W; k++)
      if (gnt_valid[k]) last_idx = gnt_idx[k*IW +: IW];
    ptr_d = ptr_q;
    if (en && !hold && |gnt_valid)
      ptr_d = IW'(rr_pos(int'(last_idx), 1, N, DIR));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
endmodule
